// File: rtl/spi_peripheral_tx.sv
// SPI peripheral transmitter: small byte FIFO feeding an MSB-first CIPO shifter.
// SCLK and CS are oversampled in the clk domain through 3-flop synchronizers.
module spi_peripheral_tx #(
    parameter bit         CPOL       = 1'b0,
    parameter bit         CPHA       = 1'b0,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] IDLE_BYTE  = 8'hFF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            SCLK,
    input  logic                            spi_cs_n,
    output logic                            CIPO,
    output logic                            cipo_oe,
    input  logic [7:0]                      tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    input  logic                            tx_flush,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            tx_busy,
    output logic                            tx_byte_done,
    output logic                            tx_underrun,
    output logic                            tx_abort
);

    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t r_state;
    state_t w_next;

    logic r_sclk_sync_0, r_sclk_sync_1, r_sclk_sync_2;
    logic r_cs_sync_0, r_cs_sync_1, r_cs_sync_2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync_0 <= CPOL;
            r_sclk_sync_1 <= CPOL;
            r_sclk_sync_2 <= CPOL;
            r_cs_sync_0   <= 1'b1;
            r_cs_sync_1   <= 1'b1;
            r_cs_sync_2   <= 1'b1;
        end else begin
            r_sclk_sync_0 <= SCLK;
            r_sclk_sync_1 <= r_sclk_sync_0;
            r_sclk_sync_2 <= r_sclk_sync_1;
            r_cs_sync_0   <= spi_cs_n;
            r_cs_sync_1   <= r_cs_sync_0;
            r_cs_sync_2   <= r_cs_sync_1;
        end
    end

    logic w_lead, w_trail, w_cap, w_launch;

    assign w_lead   = (r_sclk_sync_1 != CPOL) && (r_sclk_sync_2 == CPOL);
    assign w_trail  = (r_sclk_sync_1 == CPOL) && (r_sclk_sync_2 != CPOL);
    assign w_cap    = CPHA ? w_trail : w_lead;
    assign w_launch = CPHA ? w_lead : w_trail;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          w_empty, w_push, w_pop, w_load;

    assign w_empty    = (r_level == '0);
    assign tx_ready   = (r_level < LW'(FIFO_DEPTH));
    assign w_push     = tx_valid && tx_ready;
    assign w_pop      = w_load && !w_empty;
    assign fifo_level = r_level;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (tx_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop)
                r_level <= r_level + LW'(1);
            else if (!w_push && w_pop)
                r_level <= r_level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !tx_flush) r_mem[r_wr_ptr] <= tx_data;
    end

    logic [7:0] r_shift_reg;
    logic [3:0] r_bit_cnt;
    logic       r_cipo_q;
    logic       r_byte_done, r_underrun, r_abort;
    logic       w_bit_inc, w_done, w_abort, w_launch_do;
    logic [2:0] w_bit_idx;
    logic [7:0] w_byte;

    assign w_bit_idx = 3'd7 - r_bit_cnt[2:0];
    assign w_byte    = w_empty ? IDLE_BYTE : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_bit_inc   = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        w_launch_do = 1'b0;
        if (r_cs_sync_2) begin
            w_next  = IDLE;
            w_abort = (r_state == SHIFT) && (r_bit_cnt != 4'd0);
        end else begin
            unique case (r_state)
                IDLE: w_next = LOAD;
                LOAD: begin
                    w_load = 1'b1;
                    w_next = SHIFT;
                end
                SHIFT: begin
                    if (w_cap) begin
                        w_bit_inc = 1'b1;
                        if (r_bit_cnt == 4'd7) begin
                            w_done = 1'b1;
                            w_next = LOAD;
                        end
                    end
                    // CPHA=0 already presented bit 7 during LOAD
                    if (w_launch && (CPHA || r_bit_cnt != 4'd0))
                        w_launch_do = 1'b1;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift_reg <= '0;
            r_bit_cnt   <= '0;
            r_cipo_q    <= 1'b0;
            r_byte_done <= 1'b0;
            r_underrun  <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_byte_done <= w_done;
            r_underrun  <= w_load && w_empty;
            r_abort     <= w_abort;
            if (w_load) begin
                r_shift_reg <= w_byte;
                r_bit_cnt   <= '0;
            end else if (w_bit_inc) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            if (r_state == IDLE)
                r_cipo_q <= 1'b0;
            else if (w_load && !CPHA)
                r_cipo_q <= w_byte[7];
            else if (w_launch_do)
                r_cipo_q <= r_shift_reg[w_bit_idx];
        end
    end

    assign CIPO         = r_cipo_q;
    assign cipo_oe      = (r_state != IDLE) && !r_cs_sync_2;
    assign tx_busy      = (r_state != IDLE);
    assign tx_byte_done = r_byte_done;
    assign tx_underrun  = r_underrun;
    assign tx_abort     = r_abort;

endmodule

// File: tb/tb_spi_peripheral_tx.sv
// Bench for spi_peripheral_tx: a mode 0 and a mode 3 instance driven by a
// bit-banged SPI controller, received bytes scored against an expected queue.
module tb_spi_peripheral_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       sclk0, cs0_n, cipo0, oe0, txv0, rdy0, fl0, busy0, done0, und0, abo0;
    logic       sclk3, cs3_n, cipo3, oe3, txv3, rdy3, fl3, busy3, done3, und3, abo3;
    logic [7:0] txd0, txd3;
    logic [2:0] lvl0, lvl3;

    spi_peripheral_tx #(.CPOL(1'b0), .CPHA(1'b0), .FIFO_DEPTH(4), .IDLE_BYTE(8'hFF)) u_m0 (
        .clk(clk), .rst_n(rst_n), .SCLK(sclk0), .spi_cs_n(cs0_n),
        .CIPO(cipo0), .cipo_oe(oe0), .tx_data(txd0), .tx_valid(txv0),
        .tx_ready(rdy0), .tx_flush(fl0), .fifo_level(lvl0), .tx_busy(busy0),
        .tx_byte_done(done0), .tx_underrun(und0), .tx_abort(abo0));

    spi_peripheral_tx #(.CPOL(1'b1), .CPHA(1'b1), .FIFO_DEPTH(4), .IDLE_BYTE(8'hFF)) u_m3 (
        .clk(clk), .rst_n(rst_n), .SCLK(sclk3), .spi_cs_n(cs3_n),
        .CIPO(cipo3), .cipo_oe(oe3), .tx_data(txd3), .tx_valid(txv3),
        .tx_ready(rdy3), .tx_flush(fl3), .fifo_level(lvl3), .tx_busy(busy3),
        .tx_byte_done(done3), .tx_underrun(und3), .tx_abort(abo3));

    int checks = 0;
    int failures = 0;
    int dn0 = 0, un0 = 0, ab0 = 0, dn3 = 0, un3 = 0, ab3 = 0;
    logic [7:0] q0[$];
    logic [7:0] q3[$];

    always @(negedge clk) begin
        if (done0) dn0++;
        if (und0)  un0++;
        if (abo0)  ab0++;
        if (done3) dn3++;
        if (und3)  un3++;
        if (abo3)  ab3++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int m, input logic [7:0] b);
        if (m == 0) begin
            txd0 = b; txv0 = 1'b1; q0.push_back(b);
        end else begin
            txd3 = b; txv3 = 1'b1; q3.push_back(b);
        end
        wclk(1);
        txv0 = 1'b0;
        txv3 = 1'b0;
    endtask

    // controller samples CIPO on the rising SCLK edge in both modes
    task automatic sclk_bits(input int m, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            if (m == 0) begin
                rx = {rx[6:0], cipo0};
                sclk0 = 1'b1; wclk(4);
                sclk0 = 1'b0; wclk(4);
            end else begin
                sclk3 = 1'b0; wclk(4);
                rx = {rx[6:0], cipo3};
                sclk3 = 1'b1; wclk(4);
            end
        end
    endtask

    task automatic xfer(input int m, input int nbytes);
        logic [7:0] rx, exp;
        int d0, u0, exp_und;
        d0 = (m == 0) ? dn0 : dn3;
        u0 = (m == 0) ? un0 : un3;
        exp_und = 0;
        if (m == 0) cs0_n = 1'b0; else cs3_n = 1'b0;
        wclk(8);
        for (int b = 0; b < nbytes; b++) begin
            sclk_bits(m, 8, rx);
            if (m == 0 ? q0.size() == 0 : q3.size() == 0) begin
                exp = 8'hFF;
                exp_und++;
            end else begin
                exp = (m == 0) ? q0.pop_front() : q3.pop_front();
            end
            check_eq($sformatf("m%0d_rx%0d", m, b), {24'd0, rx}, {24'd0, exp});
        end
        // the reload after the last byte pops a byte that is then dropped
        if (m == 0 ? q0.size() == 0 : q3.size() == 0) exp_und++;
        else if (m == 0) void'(q0.pop_front());
        else void'(q3.pop_front());
        wclk(4);
        if (m == 0) cs0_n = 1'b1; else cs3_n = 1'b1;
        wclk(8);
        check_eq($sformatf("m%0d_done_cnt", m), (m == 0 ? dn0 : dn3) - d0, nbytes);
        check_eq($sformatf("m%0d_und_cnt", m), (m == 0 ? un0 : un3) - u0, exp_und);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] rx;
        int a0;
        sclk0 = 1'b0; cs0_n = 1'b1; txd0 = '0; txv0 = 1'b0; fl0 = 1'b0;
        sclk3 = 1'b1; cs3_n = 1'b1; txd3 = '0; txv3 = 1'b0; fl3 = 1'b0;
        wclk(3);
        check_eq("rst_cipo", cipo0, 1'b0);
        check_eq("rst_oe", oe0, 1'b0);
        check_eq("rst_ready", rdy0, 1'b1);
        check_eq("rst_level", lvl0, 3'd0);
        check_eq("rst_busy", busy0, 1'b0);
        check_eq("rst_pulses", {done0, und0, abo0}, 3'b000);
        check_eq("rst_cipo3", cipo3, 1'b0);
        rst_n = 1'b1;
        wclk(2);

        push(0, 8'hA5);
        check_eq("m0_level_1", lvl0, 3'd1);
        xfer(0, 1);
        check_eq("m0_level_0", lvl0, 3'd0);

        push(3, 8'h3C);
        push(3, 8'hC3);
        check_eq("m3_level_2", lvl3, 3'd2);
        xfer(3, 2);
        check_eq("m3_level_0", lvl3, 3'd0);

        xfer(0, 1);

        push(0, 8'h11);
        push(0, 8'h22);
        push(0, 8'h33);
        push(0, 8'h44);
        check_eq("full_level", lvl0, 3'd4);
        check_eq("full_ready", rdy0, 1'b0);
        txd0 = 8'h55; txv0 = 1'b1; q0.push_back(8'h55);
        wclk(3);
        check_eq("full_held", lvl0, 3'd4);
        fork
            xfer(0, 1);
            begin
                bit ok;
                ok = 1'b0;
                for (int k = 0; k < 400 && !ok; k++) begin
                    @(posedge clk);
                    if (rdy0) ok = 1'b1;
                end
                #1 txv0 = 1'b0;
                check_eq("held_push_accepted", ok, 1'b1);
            end
        join
        check_eq("after_pop_level", lvl0, 3'd3);
        fl0 = 1'b1;
        wclk(1);
        fl0 = 1'b0;
        q0.delete();
        check_eq("flush_level", lvl0, 3'd0);
        fl0 = 1'b1; txd0 = 8'h77; txv0 = 1'b1;
        wclk(1);
        fl0 = 1'b0; txv0 = 1'b0;
        check_eq("flush_push_level", lvl0, 3'd0);
        check_eq("flush_ready", rdy0, 1'b1);

        push(0, 8'h81);
        a0 = ab0;
        cs0_n = 1'b0;
        wclk(8);
        sclk_bits(0, 3, rx);
        check_eq("abort_bits", rx, 8'h04);
        cs0_n = 1'b1;
        wclk(4);
        check_eq("abort_oe", oe0, 1'b0);
        wclk(2);
        check_eq("abort_cnt", ab0 - a0, 1);
        check_eq("abort_busy", busy0, 1'b0);
        void'(q0.pop_front());
        xfer(0, 1);

        push(0, 8'h5A);
        push(0, 8'h66);
        cs0_n = 1'b0;
        wclk(8);
        sclk_bits(0, 4, rx);
        sclk0 = 1'b1;
        wclk(2);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_oe", oe0, 1'b0);
        check_eq("mid_rst_busy", busy0, 1'b0);
        check_eq("mid_rst_level", lvl0, 3'd0);
        check_eq("mid_rst_ready", rdy0, 1'b1);
        check_eq("mid_rst_cipo", cipo0, 1'b0);
        sclk0 = 1'b0; cs0_n = 1'b1;
        wclk(2);
        rst_n = 1'b1;
        wclk(2);
        q0.delete();
        xfer(0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
